// File: rtl/aer_pkg.sv
// Shared AER link constants and the transmitter handshake state encoding.
package aer_pkg;

    localparam int AER_IN_W  = 10;
    localparam int AER_OUT_W = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETUP   = 2'd1,
        WAIT_HI = 2'd2,
        WAIT_LO = 2'd3
    } aer_tx_state_t;

endpackage

// File: rtl/aer_fifo.sv
// Synchronous first-word-fall-through FIFO; rdata_o is valid whenever empty_o is low.
module aer_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/aer_in_transmitter.sv
// Host-side AER input-link transmitter: buffers events and drives a 4-phase
// REQ/ACK handshake per event against a resynchronised ACK.
module aer_in_transmitter
    import aer_pkg::*;
#(
    parameter int ADDR_W      = AER_IN_W,
    parameter int FIFO_DEPTH  = 8,
    parameter int SETUP_CYC   = 1,
    parameter int TIMEOUT_CYC = 1024,
    parameter int CNT_W       = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              TX_EN,
    input  logic              EVT_VALID,
    input  logic [ADDR_W-1:0] EVT_ADDR,
    output logic              EVT_READY,
    output logic [ADDR_W-1:0] AERIN_ADDR,
    output logic              AERIN_REQ,
    input  logic              AERIN_ACK,
    output logic              BUSY,
    output logic [CNT_W-1:0]  SENT_CNT,
    output logic              TIMEOUT_ERR
);

    localparam int SW = (SETUP_CYC > 1) ? $clog2(SETUP_CYC) : 1;
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [SW-1:0] SETUP_LAST   = SW'(SETUP_CYC - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYC - 1);
    localparam bit            TIMEOUT_EN   = (TIMEOUT_CYC != 0);

    aer_tx_state_t     state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              req_q, req_d;
    logic [CNT_W-1:0]  sent_q, sent_d;
    logic              terr_q, terr_d;
    logic [SW-1:0]     setup_cnt_q, setup_cnt_d;
    logic [TW-1:0]     wait_cnt_q, wait_cnt_d;
    logic              acked_q, acked_d;
    logic              ack_meta_q, ack_s_q;

    logic              fifo_pop;
    logic [ADDR_W-1:0] fifo_rdata;
    logic              fifo_full;
    logic              fifo_empty;

    aer_fifo #(
        .WIDTH (ADDR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (CLK),
        .rst_i   (RST),
        .push_i  (EVT_VALID),
        .wdata_i (EVT_ADDR),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        req_d       = req_q;
        sent_d      = sent_q;
        terr_d      = terr_q;
        setup_cnt_d = setup_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        acked_d     = acked_q;
        fifo_pop    = 1'b0;
        case (state_q)
            IDLE: begin
                // A still-high ACK belongs to the previous handshake; wait it out.
                if (TX_EN && !fifo_empty && !ack_s_q) begin
                    fifo_pop    = 1'b1;
                    addr_d      = fifo_rdata;
                    setup_cnt_d = '0;
                    state_d     = SETUP;
                end
            end
            SETUP: begin
                if (setup_cnt_q == SETUP_LAST) begin
                    req_d      = 1'b1;
                    wait_cnt_d = '0;
                    state_d    = WAIT_HI;
                end else begin
                    setup_cnt_d = setup_cnt_q + SW'(1);
                end
            end
            WAIT_HI: begin
                if (ack_s_q) begin
                    req_d      = 1'b0;
                    acked_d    = 1'b1;
                    wait_cnt_d = '0;
                    state_d    = WAIT_LO;
                end else if (TIMEOUT_EN && wait_cnt_q == TIMEOUT_LAST) begin
                    terr_d     = 1'b1;
                    req_d      = 1'b0;
                    acked_d    = 1'b0;
                    wait_cnt_d = '0;
                    state_d    = WAIT_LO;
                end else begin
                    wait_cnt_d = wait_cnt_q + TW'(1);
                end
            end
            WAIT_LO: begin
                // Only a handshake whose ACK was actually seen high gets counted.
                if (!ack_s_q) begin
                    if (acked_q) sent_d = sent_q + CNT_W'(1);
                    state_d = IDLE;
                end else if (TIMEOUT_EN && wait_cnt_q == TIMEOUT_LAST) begin
                    terr_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    acked_d    = 1'b1;
                    wait_cnt_d = wait_cnt_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            req_q       <= 1'b0;
            sent_q      <= '0;
            terr_q      <= 1'b0;
            setup_cnt_q <= '0;
            wait_cnt_q  <= '0;
            acked_q     <= 1'b0;
            ack_meta_q  <= 1'b0;
            ack_s_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            req_q       <= req_d;
            sent_q      <= sent_d;
            terr_q      <= terr_d;
            setup_cnt_q <= setup_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            acked_q     <= acked_d;
            ack_meta_q  <= AERIN_ACK;
            ack_s_q     <= ack_meta_q;
        end
    end

    assign EVT_READY   = !fifo_full;
    assign AERIN_ADDR  = addr_q;
    assign AERIN_REQ   = req_q;
    assign BUSY        = (state_q != IDLE) || !fifo_empty;
    assign SENT_CNT    = sent_q;
    assign TIMEOUT_ERR = terr_q;

endmodule

// File: tb/tb_aer_in_transmitter.sv
// Directed-vector bench for aer_in_transmitter with a behavioural AER responder.
module tb_aer_in_transmitter;

    logic        clk;
    logic        rst;
    logic        tx_en;
    logic        evt_valid;
    logic [9:0]  evt_addr;
    logic        evt_ready;
    logic [9:0]  aerin_addr;
    logic        aerin_req;
    logic        aerin_ack;
    logic        busy;
    logic [15:0] sent_cnt;
    logic        terr;

    logic        ack_resp;
    logic        ack_man;
    logic        resp_en;
    int          hi_dly;
    int          lo_dly;
    int          rcnt;
    int          cyc;
    int          checks;
    int          errors;
    logic [9:0]  addr_log[$];

    assign aerin_ack = ack_resp | ack_man;

    aer_in_transmitter #(
        .ADDR_W      (10),
        .FIFO_DEPTH  (8),
        .SETUP_CYC   (1),
        .TIMEOUT_CYC (16),
        .CNT_W       (16)
    ) dut (
        .CLK         (clk),
        .RST         (rst),
        .TX_EN       (tx_en),
        .EVT_VALID   (evt_valid),
        .EVT_ADDR    (evt_addr),
        .EVT_READY   (evt_ready),
        .AERIN_ADDR  (aerin_addr),
        .AERIN_REQ   (aerin_req),
        .AERIN_ACK   (aerin_ack),
        .BUSY        (busy),
        .SENT_CNT    (sent_cnt),
        .TIMEOUT_ERR (terr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Responder: raises ACK hi_dly cycles after REQ is seen, drops it lo_dly after REQ falls.
    initial begin
        ack_resp = 1'b0;
        rcnt = 0;
        forever begin
            @(negedge clk);
            if (!resp_en) begin
                ack_resp = 1'b0;
                rcnt = 0;
            end else if (!ack_resp) begin
                if (aerin_req) begin
                    rcnt++;
                    if (rcnt >= hi_dly) begin ack_resp = 1'b1; rcnt = 0; end
                end else rcnt = 0;
            end else begin
                if (!aerin_req) begin
                    rcnt++;
                    if (rcnt >= lo_dly) begin ack_resp = 1'b0; rcnt = 0; end
                end else rcnt = 0;
            end
        end
    end

    // Link monitor: logs the address at every REQ rise and checks it stays put while REQ is high.
    initial begin
        logic       prev_req;
        logic [9:0] prev_addr;
        prev_req = 1'b0;
        prev_addr = '0;
        forever begin
            @(negedge clk);
            if (aerin_req && !prev_req) addr_log.push_back(aerin_addr);
            if (aerin_req && prev_req) begin
                checks++;
                if (aerin_addr !== prev_addr) begin
                    errors++;
                    $display("FAIL addr_stable_during_req: got %h, expected %h", aerin_addr, prev_addr);
                end
            end
            prev_req = aerin_req;
            prev_addr = aerin_addr;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resp_en = 1'b0;
        ack_man = 1'b0;
        evt_valid = 1'b0;
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        tx_en = 1'b1;
        resp_en = 1'b1;
        addr_log.delete();
    endtask

    task automatic push(input logic [9:0] a, output bit ok);
        logic rdy;
        evt_addr = a;
        evt_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            rdy = evt_ready;
            step(1);
            if (rdy) begin ok = 1'b1; break; end
        end
        evt_valid = 1'b0;
    endtask

    task automatic wait_req(input logic lvl, input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (aerin_req === lvl) begin ok = 1'b1; break; end
            step(1);
        end
        if (aerin_req === lvl) ok = 1'b1;
    endtask

    task automatic wait_sent(input int n, input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (sent_cnt == 16'(n) && busy === 1'b0) begin ok = 1'b1; break; end
            step(1);
        end
        if (sent_cnt == 16'(n) && busy === 1'b0) ok = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tx_en = 1'b1;
        evt_valid = 1'b0;
        evt_addr = '0;
        resp_en = 1'b0;
        ack_man = 1'b0;
        step(2);
        rst = 1'b0;
        step(1);
        checks++; if (aerin_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b, expected 0", aerin_req); end
        checks++; if (aerin_addr !== 10'h000) begin errors++; $display("FAIL reset_addr: got %h, expected 000", aerin_addr); end
        checks++; if (sent_cnt !== 16'd0) begin errors++; $display("FAIL reset_sent: got %0d, expected 0", sent_cnt); end
        checks++; if (terr !== 1'b0) begin errors++; $display("FAIL reset_terr: got %b, expected 0", terr); end
        checks++; if (evt_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b, expected 1", evt_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, expected 0", busy); end
    endtask

    task automatic test_single();
        bit ok;
        do_reset();
        hi_dly = 2;
        lo_dly = 2;
        push(10'h155, ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_push: got refused, expected accepted"); end
        step(1);
        checks++; if (aerin_addr !== 10'h155) begin errors++; $display("FAIL single_addr_k1: got %h, expected 155", aerin_addr); end
        checks++; if (aerin_req !== 1'b0) begin errors++; $display("FAIL single_req_k1: got %b, expected 0", aerin_req); end
        step(1);
        checks++; if (aerin_req !== 1'b1) begin errors++; $display("FAIL single_req_k2: got %b, expected 1", aerin_req); end
        wait_sent(1, 100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_done: got sent=%0d busy=%b, expected sent=1 busy=0", sent_cnt, busy); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy: got %b, expected 0", busy); end
    endtask

    task automatic test_burst();
        bit ok;
        do_reset();
        hi_dly = 5;
        lo_dly = 4;
        tx_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            push(10'(i), ok);
            checks++; if (!ok) begin errors++; $display("FAIL burst_push%0d: got refused, expected accepted", i); end
        end
        checks++; if (evt_ready !== 1'b0) begin errors++; $display("FAIL burst_full_ready: got %b, expected 0", evt_ready); end
        tx_en = 1'b1;
        for (int i = 8; i < 10; i++) begin
            push(10'(i), ok);
            checks++; if (!ok) begin errors++; $display("FAIL burst_push%0d: got refused, expected accepted", i); end
        end
        wait_sent(10, 800, ok);
        checks++; if (sent_cnt !== 16'd10) begin errors++; $display("FAIL burst_sent: got %0d, expected 10", sent_cnt); end
        checks++; if (addr_log.size() != 10) begin errors++; $display("FAIL burst_log_size: got %0d, expected 10", addr_log.size()); end
        for (int i = 0; i < addr_log.size() && i < 10; i++) begin
            checks++;
            if (addr_log[i] !== 10'(i)) begin errors++; $display("FAIL burst_order%0d: got %h, expected %h", i, addr_log[i], 10'(i)); end
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int t_rise;
        do_reset();
        resp_en = 1'b0;
        push(10'h2AA, ok);
        wait_req(1'b1, 20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL timeout_req_rise: got %b, expected 1", aerin_req); end
        t_rise = cyc;
        wait_req(1'b0, 40, ok);
        checks++; if (cyc - t_rise != 16) begin errors++; $display("FAIL timeout_req_fall: got %0d cycles, expected 16", cyc - t_rise); end
        checks++; if (terr !== 1'b1) begin errors++; $display("FAIL timeout_err: got %b, expected 1", terr); end
        wait_sent(0, 40, ok);
        checks++; if (!ok || sent_cnt !== 16'd0) begin errors++; $display("FAIL timeout_sent: got %0d busy=%b, expected 0 idle", sent_cnt, busy); end
        hi_dly = 2;
        lo_dly = 2;
        resp_en = 1'b1;
        push(10'h0A5, ok);
        wait_sent(1, 100, ok);
        checks++; if (sent_cnt !== 16'd1) begin errors++; $display("FAIL timeout_next_sent: got %0d, expected 1", sent_cnt); end
        checks++; if (addr_log.size() != 2 || addr_log[addr_log.size()-1] !== 10'h0A5) begin
            errors++; $display("FAIL timeout_next_addr: got %0d entries, expected last 0a5", addr_log.size()); end
        checks++; if (terr !== 1'b1) begin errors++; $display("FAIL timeout_sticky: got %b, expected 1", terr); end
    endtask

    task automatic test_stale_ack();
        bit ok;
        do_reset();
        resp_en = 1'b0;
        ack_man = 1'b1;
        step(4);
        push(10'h0F0, ok);
        step(6);
        checks++; if (aerin_req !== 1'b0) begin errors++; $display("FAIL stale_req: got %b, expected 0", aerin_req); end
        checks++; if (aerin_addr !== 10'h000) begin errors++; $display("FAIL stale_no_pop: got %h, expected 000", aerin_addr); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL stale_busy: got %b, expected 1", busy); end
        hi_dly = 2;
        lo_dly = 2;
        ack_man = 1'b0;
        resp_en = 1'b1;
        wait_sent(1, 100, ok);
        checks++; if (sent_cnt !== 16'd1) begin errors++; $display("FAIL stale_sent: got %0d, expected 1", sent_cnt); end
        checks++; if (addr_log.size() != 1 || addr_log[0] !== 10'h0F0) begin
            errors++; $display("FAIL stale_addr: got %0d entries, expected one 0f0", addr_log.size()); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        resp_en = 1'b0;
        addr_log.delete();
        push(10'h3C3, ok);
        push(10'h111, ok);
        push(10'h222, ok);
        wait_req(1'b1, 20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rstmid_req_rise: got %b, expected 1", aerin_req); end
        rst = 1'b1;
        step(1);
        checks++; if (aerin_req !== 1'b0) begin errors++; $display("FAIL rstmid_req: got %b, expected 0", aerin_req); end
        checks++; if (aerin_addr !== 10'h000) begin errors++; $display("FAIL rstmid_addr: got %h, expected 000", aerin_addr); end
        checks++; if (sent_cnt !== 16'd0) begin errors++; $display("FAIL rstmid_sent: got %0d, expected 0", sent_cnt); end
        checks++; if (evt_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b, expected 1", evt_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b, expected 0", busy); end
        rst = 1'b0;
        step(6);
        checks++; if (aerin_req !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL rstmid_discard: got req=%b busy=%b, expected 0 0", aerin_req, busy); end
    endtask

    task automatic test_tx_en_gating();
        bit ok;
        do_reset();
        hi_dly = 4;
        lo_dly = 2;
        tx_en = 1'b0;
        push(10'h101, ok);
        push(10'h102, ok);
        push(10'h103, ok);
        push(10'h104, ok);
        tx_en = 1'b1;
        wait_req(1'b1, 20, ok);
        tx_en = 1'b0;
        wait_sent(1, 100, ok);
        step(10);
        checks++; if (sent_cnt !== 16'd1) begin errors++; $display("FAIL txen_sent_held: got %0d, expected 1", sent_cnt); end
        checks++; if (aerin_req !== 1'b0) begin errors++; $display("FAIL txen_req_held: got %b, expected 0", aerin_req); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL txen_queue_held: got busy=%b, expected 1", busy); end
        checks++; if (aerin_addr !== 10'h101) begin errors++; $display("FAIL txen_addr_held: got %h, expected 101", aerin_addr); end
        tx_en = 1'b1;
        wait_sent(4, 300, ok);
        checks++; if (sent_cnt !== 16'd4) begin errors++; $display("FAIL txen_sent_all: got %0d, expected 4", sent_cnt); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= addr_log.size() || addr_log[i] !== 10'(10'h101 + i)) begin
                errors++; $display("FAIL txen_order%0d: got %0d entries, expected addr %h", i, addr_log.size(), 10'(10'h101 + i)); end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc = 0;
        hi_dly = 2;
        lo_dly = 2;
        test_reset();
        test_single();
        test_burst();
        test_timeout();
        test_stale_ack();
        test_reset_mid();
        test_tx_en_gating();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
